// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared types and constants for the 1:4 TDM demultiplexer.
//            Provides the channel count, the slot width and type, the routing
//            mode encoding, the round-robin slot states and their successor
//            function.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } demux_mode_e;

  // Round-robin pointer states; the encoding equals the slot number.
  typedef enum logic [SLOT_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_state_e;

  function automatic slot_state_e next_slot(input slot_state_e s);
    slot_state_e n;
    case (s)
      S0:      n = S1;
      S1:      n = S2;
      S2:      n = S3;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_demux_1to4_chan_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux_chan_reg
// Purpose  : One-entry holding register for a single demux output channel.
//            A load always wins over a drain, so a word can pass through at
//            full rate. The last word stays in q after it is drained.
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset
//            load     - capture d this edge (the caller gates it with can_load)
//            d        - incoming word
//            ack      - consumer takes the held word
//            q        - held word
//            valid    - register holds an unconsumed word
//            can_load - register is empty or is being drained this cycle
// Revision : 1.0 - initial release
// ============================================================================
module demux_chan_reg
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ack,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         can_load
);

  assign can_load = ~valid | ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ack) begin
      // An ack on an empty register leaves it empty.
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1to4
// Purpose  : Four-channel time-division demultiplexer. Words arriving on a
//            valid/ready stream are steered to one of four holding registers,
//            either by in_sel (mode=0) or by a round-robin slot pointer
//            (mode=1). A stalled channel back-pressures only the words that
//            target it.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            mode                - 0 explicit select, 1 round-robin
//            resync              - forces the slot pointer to 0 next edge
//            in_valid/in_ready   - input handshake
//            in_data, in_sel     - input word and explicit target channel
//            out_data            - channel c in bits [c*W +: W]
//            out_valid, out_ack  - per-channel output handshake
//            slot                - current round-robin pointer
//            frame_done          - pulses the cycle after a slot-3 accept
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                resync,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic [SLOT_W-1:0]   in_sel,
  output logic [NUM_CH*W-1:0] out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ack,
  output logic [SLOT_W-1:0]   slot,
  output logic                frame_done
);

  slot_state_e           state;
  slot_state_e           state_nxt;
  logic                  frame_done_nxt;
  slot_t                 tgt;
  logic                  accept;
  logic                  rr_mode;
  logic [NUM_CH-1:0]     load;
  logic [NUM_CH-1:0]     can_load;

  assign rr_mode = (demux_mode_e'(mode) == MODE_RR);
  assign tgt     = rr_mode ? slot_t'(state) : in_sel;
  assign in_ready = can_load[tgt];
  assign accept  = in_valid & in_ready;
  assign slot    = slot_t'(state);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign load[c] = accept & (tgt == slot_t'(c));

      demux_chan_reg #(
        .W (W)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[c]),
        .d        (in_data),
        .ack      (out_ack[c]),
        .q        (out_data[c*W +: W]),
        .valid    (out_valid[c]),
        .can_load (can_load[c])
      );
    end
  endgenerate

  // Slot pointer state register and registered frame marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // The pointer only moves on round-robin accepts. Resync overrides the
  // advance, but the word accepted on that edge still used the old slot, so
  // the frame marker is decided from the old state independently.
  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    if (rr_mode && accept) begin
      state_nxt      = next_slot(state);
      frame_done_nxt = (state == S3);
    end
    if (resync) begin
      state_nxt = S0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_1to4
// Purpose  : Self-checking bench for tdm_demux_1to4 with a behavioural model
//            of the four holding registers, the slot counter and frame marker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1to4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode = 1'b0;
  logic         resync = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic [4*W-1:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ack = '0;
  logic [1:0]   slot;
  logic         frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic         mv [4];
  logic [W-1:0] md [4];
  int           mslot;
  logic         mfd;

  tdm_demux_1to4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .resync     (resync),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .slot       (slot),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      mv[c] = 1'b0;
      md[c] = '0;
    end
    mslot = 0;
    mfd   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, {28'd0, out_valid}, {28'd0, mv[3], mv[2], mv[1], mv[0]});
    chk({tag, ".data"}, out_data, {md[3], md[2], md[1], md[0]});
    chk({tag, ".slot"}, {30'd0, slot}, mslot);
    chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, mfd});
  endtask

  // One clock cycle: drive inputs, check ready, clock, update model, check.
  task automatic step(input logic m, input logic rs, input logic v,
                      input logic [W-1:0] d, input logic [1:0] s,
                      input logic [3:0] a, output logic acc);
    int   tgt;
    logic rdy;
    mode = m; resync = rs; in_valid = v; in_data = d; in_sel = s; out_ack = a;
    #1;
    tgt = m ? mslot : int'(s);
    rdy = !mv[tgt] || a[tgt];
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    acc = v && rdy;
    mfd = m && acc && (mslot == 3);
    for (int c = 0; c < 4; c++) begin
      if (acc && c == tgt) begin
        mv[c] = 1'b1;
        md[c] = d;
      end else if (a[c]) begin
        mv[c] = 1'b0;
      end
    end
    if (rs)            mslot = 0;
    else if (m && acc) mslot = (mslot + 1) % 4;
    #1;
    check_state("cycle");
  endtask

  initial begin
    logic acc;
    logic [7:0] wsel [4];
    logic [7:0] wdat [4];
    wsel[0] = 8'd2; wsel[1] = 8'd0; wsel[2] = 8'd3; wsel[3] = 8'd1;
    wdat[0] = 8'hA1; wdat[1] = 8'hB2; wdat[2] = 8'hC3; wdat[3] = 8'hD4;

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("reset");
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

    // Explicit routing, no acks
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, wdat[i], wsel[i][1:0], 4'b0000, acc);
    chk("explicit.valid", {28'd0, out_valid}, 32'h0000000F);
    chk("explicit.data", out_data, 32'hC3A1D4B2);
    step(1'b0, 1'b0, 1'b1, 8'hEE, 2'd2, 4'b0000, acc);
    chk("explicit.fifth_blocked", {31'd0, acc}, 32'd0);

    // Round-robin frame with all channels acked
    for (int i = 0; i < 8; i++) begin
      chk("rr.slot_before", {30'd0, slot}, i % 4);
      step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 2'd0, 4'b1111, acc);
      chk("rr.accepted", {31'd0, acc}, 32'd1);
      chk("rr.frame_done", {31'd0, frame_done}, (i % 4 == 3) ? 32'd1 : 32'd0);
    end
    chk("rr.ch3", {24'd0, out_data[3*W +: W]}, 32'h17);

    // Same-edge ack and load on ch1
    step(1'b0, 1'b0, 1'b1, 8'h55, 2'd1, 4'b0000, acc);
    step(1'b0, 1'b0, 1'b1, 8'h66, 2'd1, 4'b0010, acc);
    chk("passthru.ch1", {24'd0, out_data[1*W +: W]}, 32'h66);
    chk("passthru.valid1", {31'd0, out_valid[1]}, 32'd1);

    // Resync with accept at slot 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 2'd0, 4'b1111, acc);
    chk("resync.slot3", {30'd0, slot}, 32'd3);
    step(1'b1, 1'b1, 1'b1, 8'h77, 2'd0, 4'b1111, acc);
    chk("resync.ch3", {24'd0, out_data[3*W +: W]}, 32'h77);
    chk("resync.slot0", {30'd0, slot}, 32'd0);
    chk("resync.pulse", {31'd0, frame_done}, 32'd1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h30 + i), 2'd0, 4'b1111, acc);
    step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1111, acc);
    chk("resync_idle.slot", {30'd0, slot}, 32'd0);
    chk("resync_idle.no_pulse", {31'd0, frame_done}, 32'd0);

    // Set up out_valid=1010, slot=2, then reset asynchronously
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 2'd0, 4'b1111, acc);
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111, acc);
    step(1'b0, 1'b0, 1'b1, 8'h5A, 2'd1, 4'b0000, acc);
    step(1'b0, 1'b0, 1'b1, 8'hA5, 2'd3, 4'b0000, acc);
    chk("midreset.pre_valid", {28'd0, out_valid}, 32'hA);
    chk("midreset.pre_slot", {30'd0, slot}, 32'd2);
    in_valid = 1'b0; out_ack = '0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("after_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
           4'($urandom), acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Four-channel time-division demultiplexer: the receive-side counterpart of the team's 4:1 selector. It accepts a single stream of W-bit words over a valid/ready handshake. Each word is steered to one of four output channels, either by an explicit 2-bit select or by an internal round-robin slot pointer. Each channel has a one-entry holding register with its own valid/ack handshake, so a stalled channel back-pressures only the words addressed to it.

## Interface
- `W`, default 8: data width per word and per channel.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = explicit select (`in_sel`), 1 = round-robin (internal pointer).
- `resync`  in  1  in round-robin mode, forces the slot pointer to 0 at the next edge.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  target channel can take the word.
- `in_data`  in  W  input word.
- `in_sel`  in  2  target channel in explicit mode; ignored in round-robin mode.
- `out_data`  out  4*W  channel c occupies bits [c*W +: W].
- `out_valid`  out  4  channel c holding register full.
- `out_ack`  in  4  consumer of channel c takes the word.
- `slot`  out  2  current round-robin pointer.
- `frame_done`  out  1  one-cycle pulse after the word for slot 3 is accepted in round-robin mode.

## Operation
- **Target channel.** `tgt = mode ? slot : in_sel`.
- **Ready.** `in_ready = ~out_valid[tgt] | out_ack[tgt]`.
  - This is combinational from `out_ack`, `mode`, `in_sel` and registered state.
- **Accept.** A word is accepted when `in_valid & in_ready` at a rising edge.
  - `out_data[tgt]` is loaded with `in_data`.
  - `out_valid[tgt]` is set.
- **Drain.** `out_valid[c] & out_ack[c]` clears `out_valid[c]` unless the same edge also accepts a word into channel c. In that case the register reloads and valid stays 1 (pass-through at full rate).
- **Ack on empty.** `out_ack[c]` while `out_valid[c]=0` has no effect.
- **Slot pointer** (round-robin mode only).
  - Advances by 1 on each accept, wrapping 3→0. It acts as a 4-state machine S0→S1→S2→S3→S0.
  - An accept in state S3 registers `frame_done=1` for exactly the next cycle.
- **Resync.** `resync` has priority over advance.
  - A same-edge accept still goes to the old `slot`; `slot` becomes 0.
  - `frame_done` still pulses if the old `slot` was 3.
- **Explicit mode.** `slot` holds its value and `frame_done` stays 0; `resync` is still honoured.
- **Mode change.** Takes effect combinationally on `tgt`. The pointer is not reset by a mode change.
- **Untargeted channels.** Registers of channels not addressed are never disturbed.
- **Data stability.** `out_data[c]` holds its value while `out_valid[c]=1` and no reload occurs. Contents are don't-care when not valid, but the implementation keeps the last value.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - `out_valid=0`, `out_data=0`, `slot=0`, `frame_done=0`.
  - `in_ready` then evaluates to 1.
- **Reset mid-operation:** held words are discarded and no `frame_done` is emitted.
- **Latency:** accept at edge N → `out_valid[tgt]=1` and data visible after edge N.
- **Throughput:** one word per cycle sustained if the addressed channel is acked in the same cycle it is full, or is empty.
- **`frame_done`** is registered and asserted in the cycle after the slot-3 accept.
- **Handshake rules:**
  - Input side: the producer must hold `in_data`/`in_sel` stable while `in_valid & ~in_ready`. The block does not check this.
  - Output side: `out_valid` never drops without an ack or reset.

## Structure
- Package `tdm_pkg`:
  - `NUM_CH=4`, `SLOT_W=2`.
  - Typedef `slot_t` (2-bit).
  - Enum `demux_mode_e {MODE_SEL=0, MODE_RR=1}`.
- Sub-module `demux_chan_reg` (parameter W): one-entry holding register.
  - Ports: `clk`, `rst_n`, `load`, `d`, `ack`, `q`, `valid`, `can_load`.
  - Instantiated four times from a generate loop.
- Top level contains only target decode, ready mux, slot pointer and `frame_done` register.

## Test plan
- **Reset:** reset released, no traffic → `out_valid=0000`, `slot=0`, `in_ready=1`, `frame_done=0`.
- **Explicit routing:** `mode=0`, send 0xA1/0xB2/0xC3/0xD4 with `in_sel` 2,0,3,1 and no acks.
  - `out_valid=1111`, with ch0=0xB2, ch1=0xD4, ch2=0xA1, ch3=0xC3.
  - A fifth word to ch2 sees `in_ready=0`.
- **Round-robin frame:** `mode=1`, `out_ack=1111`, 8 back-to-back words 0x10..0x17.
  - Each accepted in 1 cycle; `slot` cycles 0,1,2,3,0,1,2,3.
  - `frame_done` pulses 1 cycle after 0x13 and after 0x17; ch3 ends at 0x17.
- **Same-edge ack and load:** ch1 full with 0x55, `out_ack[1]=1` while sending 0x66 to ch1.
  - `in_ready=1`; next cycle ch1=0x66 and `out_valid[1]` stays 1.
- **Resync:** `mode=1`, `slot=3`, accept 0x77 with `resync=1`.
  - ch3=0x77, `slot=0`, `frame_done` pulses.
  - Then `slot=2`, `resync` with no accept → `slot=0`, no pulse.
- **Reset mid-operation:** assert `rst_n=0` asynchronously with `out_valid=1010` and `slot=2`.
  - Outputs clear immediately without a clock edge; `slot=0`.
